// File: rtl/vx_tex_rsp_arb.sv
// Round-robin merge of NUM_REQS texture response streams into one registered
// writeback slot, with a saturating backpressure stall counter.
`timescale 1ns/1ps
module vx_tex_rsp_arb #(
  parameter int NUM_REQS    = 4,
  parameter int UUID_BITS   = 44,
  parameter int NW_BITS     = 2,
  parameter int NUM_THREADS = 4,
  parameter int NR_BITS     = 6,
  parameter int PERF_BITS   = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS*UUID_BITS-1:0]   req_uuid,
  input  logic [NUM_REQS*NW_BITS-1:0]     req_wid,
  input  logic [NUM_REQS*NUM_THREADS-1:0] req_tmask,
  input  logic [NUM_REQS*32-1:0]          req_PC,
  input  logic [NUM_REQS*NR_BITS-1:0]     req_rd,
  input  logic [NUM_REQS-1:0]             req_wb,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
  output logic [NUM_REQS-1:0]             req_ready,
  output logic                            rsp_valid,
  output logic [UUID_BITS-1:0]            rsp_uuid,
  output logic [NW_BITS-1:0]              rsp_wid,
  output logic [NUM_THREADS-1:0]          rsp_tmask,
  output logic [31:0]                     rsp_PC,
  output logic [NR_BITS-1:0]              rsp_rd,
  output logic                            rsp_wb,
  output logic [NUM_THREADS*32-1:0]       rsp_data,
  input  logic                            rsp_ready,
  output logic [PERF_BITS-1:0]            perf_stalls
);

  localparam int PTR_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int DATA_BITS = NUM_THREADS * 32;

  logic [PTR_BITS-1:0]    rr_ptr_r;
  logic [PTR_BITS-1:0]    rr_ptr_next_s;
  logic [NUM_REQS-1:0]    grant_s;
  logic [PTR_BITS-1:0]    grant_idx_s;
  logic                   grant_any_s;
  logic                   stage_en_s;
  logic                   fire_s;

  logic [UUID_BITS-1:0]   sel_uuid_s;
  logic [NW_BITS-1:0]     sel_wid_s;
  logic [NUM_THREADS-1:0] sel_tmask_s;
  logic [31:0]            sel_pc_s;
  logic [NR_BITS-1:0]     sel_rd_s;
  logic                   sel_wb_s;
  logic [DATA_BITS-1:0]   sel_data_s;

  logic                   rsp_valid_r;
  logic [UUID_BITS-1:0]   rsp_uuid_r;
  logic [NW_BITS-1:0]     rsp_wid_r;
  logic [NUM_THREADS-1:0] rsp_tmask_r;
  logic [31:0]            rsp_pc_r;
  logic [NR_BITS-1:0]     rsp_rd_r;
  logic                   rsp_wb_r;
  logic [DATA_BITS-1:0]   rsp_data_r;
  logic [PERF_BITS-1:0]   perf_stalls_r;

  // Cyclic priority scan: first valid source at or after rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_s     = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(rr_ptr_r) + k) % NUM_REQS;
      if (!grant_any_s && req_valid[idx]) begin
        grant_s[idx] = 1'b1;
        grant_idx_s  = PTR_BITS'(idx);
        grant_any_s  = 1'b1;
      end else begin
        grant_any_s  = grant_any_s;
      end
    end
  end

  // Handshake and pointer advance.
  always_comb begin
    stage_en_s = !rsp_valid_r || rsp_ready;
    req_ready  = grant_s & {NUM_REQS{stage_en_s && !reset}};
    fire_s     = |(req_valid & req_ready);
    if (grant_idx_s == PTR_BITS'(NUM_REQS - 1)) begin
      rr_ptr_next_s = '0;
    end else begin
      rr_ptr_next_s = grant_idx_s + PTR_BITS'(1);
    end
  end

  // Field multiplexer driven by the granted index.
  always_comb begin
    sel_uuid_s  = req_uuid [int'(grant_idx_s) * UUID_BITS   +: UUID_BITS];
    sel_wid_s   = req_wid  [int'(grant_idx_s) * NW_BITS     +: NW_BITS];
    sel_tmask_s = req_tmask[int'(grant_idx_s) * NUM_THREADS +: NUM_THREADS];
    sel_pc_s    = req_PC   [int'(grant_idx_s) * 32          +: 32];
    sel_rd_s    = req_rd   [int'(grant_idx_s) * NR_BITS     +: NR_BITS];
    sel_wb_s    = req_wb   [grant_idx_s];
    sel_data_s  = req_data [int'(grant_idx_s) * DATA_BITS   +: DATA_BITS];
  end

  // Output slot: load on fire, empty on drain without refill, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_uuid_r  <= '0;
      rsp_wid_r   <= '0;
      rsp_tmask_r <= '0;
      rsp_pc_r    <= 32'h0000_0000;
      rsp_rd_r    <= '0;
      rsp_wb_r    <= 1'b0;
      rsp_data_r  <= '0;
    end else if (fire_s) begin
      rsp_valid_r <= 1'b1;
      rsp_uuid_r  <= sel_uuid_s;
      rsp_wid_r   <= sel_wid_s;
      rsp_tmask_r <= sel_tmask_s;
      rsp_pc_r    <= sel_pc_s;
      rsp_rd_r    <= sel_rd_s;
      rsp_wb_r    <= sel_wb_s;
      rsp_data_r  <= sel_data_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  // Round-robin pointer moves past the source just accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if (fire_s) begin
      rr_ptr_r <= rr_ptr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Stall counter saturates instead of wrapping so perf reads never alias.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stalls_r <= '0;
    end else if (rsp_valid_r && !rsp_ready && (perf_stalls_r != {PERF_BITS{1'b1}})) begin
      perf_stalls_r <= perf_stalls_r + PERF_BITS'(1);
    end else begin
      perf_stalls_r <= perf_stalls_r;
    end
  end

  assign rsp_valid   = rsp_valid_r;
  assign rsp_uuid    = rsp_uuid_r;
  assign rsp_wid     = rsp_wid_r;
  assign rsp_tmask   = rsp_tmask_r;
  assign rsp_PC      = rsp_pc_r;
  assign rsp_rd      = rsp_rd_r;
  assign rsp_wb      = rsp_wb_r;
  assign rsp_data    = rsp_data_r;
  assign perf_stalls = perf_stalls_r;

endmodule

// File: tb/tb_vx_tex_rsp_arb.sv
// Directed-vector and scoreboard bench for vx_tex_rsp_arb; a second instance
// with a 3-bit stall counter shares the stimulus to exercise saturation.
`timescale 1ns/1ps
module tb_vx_tex_rsp_arb;
  localparam int N = 4;

  typedef logic [216:0] pay_t;

  typedef struct {
    logic [3:0] valid;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_valid;
    int         exp_src;
    int         exp_perf;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*44-1:0] req_uuid;
  logic [N*2-1:0] req_wid;
  logic [N*4-1:0] req_tmask;
  logic [N*32-1:0] req_PC;
  logic [N*6-1:0] req_rd;
  logic [N-1:0]   req_wb;
  logic [N*128-1:0] req_data;
  logic           rsp_ready;

  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [43:0]    rsp_uuid;
  logic [1:0]     rsp_wid;
  logic [3:0]     rsp_tmask;
  logic [31:0]    rsp_PC;
  logic [5:0]     rsp_rd;
  logic           rsp_wb;
  logic [127:0]   rsp_data;
  logic [31:0]    perf_stalls;

  logic [N-1:0]   sat_req_ready;
  logic           sat_rsp_valid;
  logic [43:0]    sat_rsp_uuid;
  logic [1:0]     sat_rsp_wid;
  logic [3:0]     sat_rsp_tmask;
  logic [31:0]    sat_rsp_PC;
  logic [5:0]     sat_rsp_rd;
  logic           sat_rsp_wb;
  logic [127:0]   sat_rsp_data;
  logic [2:0]     sat_perf_stalls;

  pay_t rsp_pay;
  assign rsp_pay = {rsp_uuid, rsp_wid, rsp_tmask, rsp_PC, rsp_rd, rsp_wb, rsp_data};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vx_tex_rsp_arb #(.NUM_REQS(N), .PERF_BITS(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_uuid(req_uuid),
    .req_wid(req_wid), .req_tmask(req_tmask), .req_PC(req_PC), .req_rd(req_rd),
    .req_wb(req_wb), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid),
    .rsp_tmask(rsp_tmask), .rsp_PC(rsp_PC), .rsp_rd(rsp_rd), .rsp_wb(rsp_wb),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .perf_stalls(perf_stalls)
  );

  vx_tex_rsp_arb #(.NUM_REQS(N), .PERF_BITS(3)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_uuid(req_uuid),
    .req_wid(req_wid), .req_tmask(req_tmask), .req_PC(req_PC), .req_rd(req_rd),
    .req_wb(req_wb), .req_data(req_data), .req_ready(sat_req_ready),
    .rsp_valid(sat_rsp_valid), .rsp_uuid(sat_rsp_uuid), .rsp_wid(sat_rsp_wid),
    .rsp_tmask(sat_rsp_tmask), .rsp_PC(sat_rsp_PC), .rsp_rd(sat_rsp_rd),
    .rsp_wb(sat_rsp_wb), .rsp_data(sat_rsp_data), .rsp_ready(rsp_ready),
    .perf_stalls(sat_perf_stalls)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Source payload: uuid carries the source id in its top nibble and a sequence number below.
  function automatic pay_t pay(input int i, input int seq);
    logic [43:0]  u;
    logic [1:0]   w;
    logic [3:0]   t;
    logic [31:0]  pc;
    logic [5:0]   r;
    logic         b;
    logic [127:0] d;
    u  = (44'(i) << 40) | 44'(seq);
    w  = 2'(i + seq);
    t  = 4'(i * 5 + seq);
    pc = 32'h8000_0000 + 32'(i * 8) + 32'(seq * 64);
    r  = 6'(10 + i + seq);
    b  = 1'((i + seq) % 2);
    for (int l = 0; l < 4; l++) d[l*32 +: 32] = {8'(i), 8'(l), 16'(seq)};
    return {u, w, t, pc, r, b, d};
  endfunction

  task automatic set_src(input int i, input int seq);
    pay_t p;
    p = pay(i, seq);
    req_uuid [i*44  +: 44]  = p[216:173];
    req_wid  [i*2   +: 2]   = p[172:171];
    req_tmask[i*4   +: 4]   = p[170:167];
    req_PC   [i*32  +: 32]  = p[166:135];
    req_rd   [i*6   +: 6]   = p[134:129];
    req_wb   [i]            = p[128];
    req_data [i*128 +: 128] = p[127:0];
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [3:0] er,
                              input logic ev, input int es, input int ep);
    vec_t x;
    x.valid = v; x.rdy = r; x.exp_ready = er; x.exp_valid = ev; x.exp_src = es; x.exp_perf = ep;
    return x;
  endfunction

  vec_t tbl [15];
  int   seq [N];
  logic [N-1:0] pend;
  logic [N-1:0] acc;
  pay_t sbq [N][$];
  int   src;
  int   left;

  initial begin
    // Fairness, skip, idle, backpressure and drain-with-refill, starting at rr_ptr=0, perf=0.
    tbl[0]  = mk(4'hF, 1'b1, 4'b0001, 1'b1, 0, 0);
    tbl[1]  = mk(4'hF, 1'b1, 4'b0010, 1'b1, 1, 0);
    tbl[2]  = mk(4'hF, 1'b1, 4'b0100, 1'b1, 2, 0);
    tbl[3]  = mk(4'hF, 1'b1, 4'b1000, 1'b1, 3, 0);
    tbl[4]  = mk(4'hF, 1'b1, 4'b0001, 1'b1, 0, 0);
    tbl[5]  = mk(4'hF, 1'b1, 4'b0010, 1'b1, 1, 0);
    tbl[6]  = mk(4'hA, 1'b1, 4'b1000, 1'b1, 3, 0);
    tbl[7]  = mk(4'hA, 1'b1, 4'b0010, 1'b1, 1, 0);
    tbl[8]  = mk(4'hF, 1'b1, 4'b0100, 1'b1, 2, 0);
    tbl[9]  = mk(4'h0, 1'b1, 4'b0000, 1'b0, 0, 0);
    tbl[10] = mk(4'hF, 1'b0, 4'b1000, 1'b1, 3, 0);
    tbl[11] = mk(4'hF, 1'b0, 4'b0000, 1'b1, 3, 1);
    tbl[12] = mk(4'hF, 1'b1, 4'b0001, 1'b1, 0, 1);
    tbl[13] = mk(4'h0, 1'b0, 4'b0000, 1'b1, 0, 2);
    tbl[14] = mk(4'h0, 1'b1, 4'b0000, 1'b0, 0, 2);

    reset = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_src(i, 0);

    repeat (2) @(negedge clk);
    #1;
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset perf_stalls", perf_stalls, 32'd0);
    check("reset req_ready", req_ready, 4'b0000);
    check("reset rsp_PC", rsp_PC, 32'h0000_0000);

    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b0000;

    // Backpressure on a single response, then saturation of the 3-bit counter.
    @(negedge clk);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1 check("bp grant", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    check("bp rsp_valid", rsp_valid, 1'b1);
    check("bp rsp_PC", rsp_PC, 32'h8000_0010);
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      #1 check($sformatf("bp stall%0d req_ready", s), req_ready, 4'b0000);
      @(posedge clk);
      #1;
      check($sformatf("bp stall%0d rsp", s), {rsp_valid, rsp_PC}, {1'b1, 32'h8000_0010});
      if (s == 5) begin
        check("bp perf_stalls", perf_stalls, 32'd5);
        check("bp sat perf_stalls", sat_perf_stalls, 3'd5);
      end
      if (s == 10) begin
        check("sat perf_stalls wide", perf_stalls, 32'd10);
        check("sat perf_stalls", sat_perf_stalls, 3'd7);
      end
    end

    // Reset in the middle of a held response takes effect immediately.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset rsp_valid", rsp_valid, 1'b0);
    check("midreset perf_stalls", perf_stalls, 32'd0);
    check("midreset sat perf", sat_perf_stalls, 3'd0);
    check("midreset req_ready", req_ready, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;

    for (int v = 0; v < 15; v++) begin
      @(negedge clk);
      req_valid = tbl[v].valid;
      rsp_ready = tbl[v].rdy;
      #1 check($sformatf("vec%0d req_ready", v), req_ready, tbl[v].exp_ready);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rsp_valid", v), rsp_valid, tbl[v].exp_valid);
      if (tbl[v].exp_valid)
        check($sformatf("vec%0d fields", v), rsp_pay, pay(tbl[v].exp_src, 0));
      check($sformatf("vec%0d perf", v), perf_stalls, 32'(tbl[v].exp_perf));
      check($sformatf("vec%0d sat perf", v), sat_perf_stalls,
            3'((tbl[v].exp_perf > 7) ? 7 : tbl[v].exp_perf));
    end

    // Random valid/ready traffic against per-source scoreboards.
    pend = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 1;
      set_src(i, seq[i]);
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (!pend[i]) pend[i] = ($urandom_range(0, 2) != 0);
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = req_valid & req_ready;
      check("rand grant onehot", ($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == 4'b0000), 1'b1);
      if (rsp_valid && rsp_ready) begin
        src = int'(rsp_uuid[43:40]);
        if (src < N && sbq[src].size() > 0) begin
          check("rand rsp", rsp_pay, sbq[src].pop_front());
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL rand rsp orphan: got %0h, expected no response", rsp_pay);
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          sbq[i].push_back(pay(i, seq[i]));
          seq[i]++;
          set_src(i, seq[i]);
          pend[i] = 1'b0;
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      #1;
      if (rsp_valid) begin
        src = int'(rsp_uuid[43:40]);
        if (src < N && sbq[src].size() > 0) begin
          check("drain rsp", rsp_pay, sbq[src].pop_front());
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL drain rsp orphan: got %0h, expected no response", rsp_pay);
        end
      end
      @(posedge clk);
    end
    left = 0;
    for (int i = 0; i < N; i++) left += sbq[i].size();
    check("rand all delivered", left, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
